// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two CPU-side masters (M0 fetch, M1 load/store), the shared
//   Avalon-MM memory command/response, and the current-owner indication.
//   modport slave  : arbiter view (consumes i_*, drives o_*)
//   modport master : environment view (drives i_*, observes o_*)
// Ports (signals):
//   i_m0_addr/read/burstcount, o_m0_waitrequest/readdata/readdatavalid
//   i_m1_addr/read/write/writedata/byteenable,
//   o_m1_waitrequest/readdata/readdatavalid
//   o_addr/read/write/writedata/byteenable/burstcount (memory command)
//   i_waitrequest/readdata/readdatavalid (memory response)
//   o_owner (one-hot {M1,M0}, 00 when idle)
interface mem_port_arbiter_if #(
    parameter int P_ADDR_BITS  = 32,
    parameter int P_DATA_BITS  = 32,
    parameter int P_BURST_BITS = 8
);
    logic [P_ADDR_BITS-1:0]   i_m0_addr;
    logic                     i_m0_read;
    logic [P_BURST_BITS-1:0]  i_m0_burstcount;
    logic                     o_m0_waitrequest;
    logic [P_DATA_BITS-1:0]   o_m0_readdata;
    logic                     o_m0_readdatavalid;

    logic [P_ADDR_BITS-1:0]   i_m1_addr;
    logic                     i_m1_read;
    logic                     i_m1_write;
    logic [P_DATA_BITS-1:0]   i_m1_writedata;
    logic [P_DATA_BITS/8-1:0] i_m1_byteenable;
    logic                     o_m1_waitrequest;
    logic [P_DATA_BITS-1:0]   o_m1_readdata;
    logic                     o_m1_readdatavalid;

    logic [P_ADDR_BITS-1:0]   o_addr;
    logic                     o_read;
    logic                     o_write;
    logic [P_DATA_BITS-1:0]   o_writedata;
    logic [P_DATA_BITS/8-1:0] o_byteenable;
    logic [P_BURST_BITS-1:0]  o_burstcount;
    logic                     i_waitrequest;
    logic [P_DATA_BITS-1:0]   i_readdata;
    logic                     i_readdatavalid;

    logic [1:0]               o_owner;

    modport slave (
        input  i_m0_addr, i_m0_read, i_m0_burstcount,
        output o_m0_waitrequest, o_m0_readdata, o_m0_readdatavalid,
        input  i_m1_addr, i_m1_read, i_m1_write, i_m1_writedata, i_m1_byteenable,
        output o_m1_waitrequest, o_m1_readdata, o_m1_readdatavalid,
        output o_addr, o_read, o_write, o_writedata, o_byteenable, o_burstcount,
        input  i_waitrequest, i_readdata, i_readdatavalid,
        output o_owner
    );

    modport master (
        output i_m0_addr, i_m0_read, i_m0_burstcount,
        input  o_m0_waitrequest, o_m0_readdata, o_m0_readdatavalid,
        output i_m1_addr, i_m1_read, i_m1_write, i_m1_writedata, i_m1_byteenable,
        input  o_m1_waitrequest, o_m1_readdata, o_m1_readdatavalid,
        input  o_addr, o_read, o_write, o_writedata, o_byteenable, o_burstcount,
        output i_waitrequest, i_readdata, i_readdatavalid,
        input  o_owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one Avalon-MM memory port between the instruction fetch master
//   (M0, read-only, bursting) and the load/store master (M1, single beat).
//   One transaction outstanding; the grant is held until a write is accepted
//   or every beat of a read burst has returned. Read data fans out to both
//   masters; readdatavalid goes only to the owner while in the data phase.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - mem_port_arbiter_if.slave (master requests, memory command and
//          response, o_owner)
// Configuration:
//   MEM_PORT_ARB_RR_EN defined  : round-robin on ties (master not served
//                                 last wins; first tie goes to M0)
//   MEM_PORT_ARB_RR_EN undefined: fixed priority, M1 beats M0
module mem_port_arbiter #(
    parameter int P_ADDR_BITS  = 32,
    parameter int P_DATA_BITS  = 32,
    parameter int P_BURST_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RDWAIT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              owner_q, owner_d;
    logic [P_BURST_BITS-1:0] cnt_q,   cnt_d;

    logic                    m0_req, m1_req, pick_m1;
    logic                    cmd_rd, cmd_wr;
    logic [P_BURST_BITS-1:0] m0_burst;

    assign m0_req   = bus.i_m0_read;
    assign m1_req   = bus.i_m1_read | bus.i_m1_write;
    // A zero burstcount from the fetch unit is issued as a single beat.
    assign m0_burst = (bus.i_m0_burstcount == '0) ? P_BURST_BITS'(1) : bus.i_m0_burstcount;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_m1_q;
    assign pick_m1 = m1_req & (~m0_req | ~last_m1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_m1_q <= 1'b1;
        else if (state_q == ST_IDLE && (m0_req | m1_req))
            last_m1_q <= pick_m1;
    end
`else
    assign pick_m1 = m1_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_m0_readdata = bus.i_readdata;
    assign bus.o_m1_readdata = bus.i_readdata;
    assign bus.o_owner       = owner_q;

    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        cnt_d                  = cnt_q;
        cmd_rd                 = 1'b0;
        cmd_wr                 = 1'b0;
        bus.o_addr             = '0;
        bus.o_writedata        = '0;
        bus.o_byteenable       = '0;
        bus.o_burstcount       = P_BURST_BITS'(1);
        bus.o_m0_waitrequest   = 1'b1;
        bus.o_m1_waitrequest   = 1'b1;
        bus.o_m0_readdatavalid = 1'b0;
        bus.o_m1_readdatavalid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = ST_GRANT;
                    owner_d = pick_m1 ? 2'b10 : 2'b01;
                end
            end
            ST_GRANT: begin
                if (owner_q[1]) begin
                    cmd_rd               = bus.i_m1_read;
                    cmd_wr               = bus.i_m1_write;
                    bus.o_addr           = bus.i_m1_addr;
                    bus.o_writedata      = bus.i_m1_writedata;
                    bus.o_byteenable     = bus.i_m1_byteenable;
                    bus.o_m1_waitrequest = bus.i_waitrequest;
                end else begin
                    cmd_rd               = bus.i_m0_read;
                    bus.o_addr           = bus.i_m0_addr;
                    bus.o_burstcount     = m0_burst;
                    bus.o_m0_waitrequest = bus.i_waitrequest;
                end
                if (!(cmd_rd | cmd_wr)) begin
                    // Owner withdrew before acceptance: nothing was issued.
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else if (!bus.i_waitrequest) begin
                    if (cmd_wr) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end else begin
                        state_d = ST_RDWAIT;
                        cnt_d   = owner_q[1] ? P_BURST_BITS'(1) : m0_burst;
                    end
                end
            end
            ST_RDWAIT: begin
                bus.o_m0_readdatavalid = owner_q[0] & bus.i_readdatavalid;
                bus.o_m1_readdatavalid = owner_q[1] & bus.i_readdatavalid;
                if (bus.i_readdatavalid) begin
                    cnt_d = cnt_q - P_BURST_BITS'(1);
                    if (cnt_q == P_BURST_BITS'(1)) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase

        bus.o_read  = cmd_rd;
        bus.o_write = cmd_wr;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are compared 1 unit later, well clear of the edge.
//   Define MEM_PORT_ARB_RR_EN for the round-robin build.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    mem_port_arbiter_if #(.P_ADDR_BITS(32), .P_DATA_BITS(32), .P_BURST_BITS(8)) bus ();

    mem_port_arbiter #(.P_ADDR_BITS(32), .P_DATA_BITS(32), .P_BURST_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        bus.i_m0_addr       = '0;
        bus.i_m0_read       = 1'b0;
        bus.i_m0_burstcount = '0;
        bus.i_m1_addr       = '0;
        bus.i_m1_read       = 1'b0;
        bus.i_m1_write      = 1'b0;
        bus.i_m1_writedata  = '0;
        bus.i_m1_byteenable = '0;
        bus.i_waitrequest   = 1'b0;
        bus.i_readdata      = '0;
        bus.i_readdatavalid = 1'b0;
        #2;
        chk("rst_owner", bus.o_owner, 2'b00);
        chk("rst_read", bus.o_read, 1'b0);
        chk("rst_write", bus.o_write, 1'b0);
        chk("rst_addr", bus.o_addr, 32'h0);
        chk("rst_burst", bus.o_burstcount, 8'd1);
        chk("rst_m0_wait", bus.o_m0_waitrequest, 1'b1);
        chk("rst_m1_wait", bus.o_m1_waitrequest, 1'b1);
        step();
        rst = 1'b0;
        step();

`ifdef MEM_PORT_ARB_RR_EN
        // Both masters request continuously: owners alternate M0,M1,M0,M1.
        begin
            logic [1:0] exp_own [4];
            exp_own[0] = 2'b01; exp_own[1] = 2'b10;
            exp_own[2] = 2'b01; exp_own[3] = 2'b10;
            bus.i_waitrequest   = 1'b0;
            bus.i_m0_read       = 1'b1;
            bus.i_m0_addr       = 32'h700;
            bus.i_m0_burstcount = 8'd1;
            bus.i_m1_write      = 1'b1;
            bus.i_m1_addr       = 32'h704;
            bus.i_m1_writedata  = 32'h55;
            bus.i_m1_byteenable = 4'h3;
            for (int t = 0; t < 4; t++) begin
                step(); #1;
                chk("rr_owner", bus.o_owner, exp_own[t]);
                step();
                if (exp_own[t] == 2'b01) begin
                    bus.i_readdatavalid = 1'b1;
                    #1;
                    chk("rr_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
                    step();
                    bus.i_readdatavalid = 1'b0;
                end
            end
            bus.i_m0_read  = 1'b0;
            bus.i_m1_write = 1'b0;
            #1;
            chk("rr_idle", bus.o_owner, 2'b00);
            step();
        end
`endif

        // M0 burst of 8 at 0x100 with a two-cycle stall.
        bus.i_m0_read       = 1'b1;
        bus.i_m0_addr       = 32'h100;
        bus.i_m0_burstcount = 8'd8;
        bus.i_waitrequest   = 1'b1;
        #1;
        chk("t1_idle_owner", bus.o_owner, 2'b00);
        chk("t1_idle_read", bus.o_read, 1'b0);
        step(); #1;
        chk("t1_owner", bus.o_owner, 2'b01);
        chk("t1_read_c1", bus.o_read, 1'b1);
        chk("t1_addr", bus.o_addr, 32'h100);
        chk("t1_burst", bus.o_burstcount, 8'd8);
        chk("t1_m0_wait_c1", bus.o_m0_waitrequest, 1'b1);
        chk("t1_m1_wait", bus.o_m1_waitrequest, 1'b1);
        step(); #1;
        chk("t1_read_c2", bus.o_read, 1'b1);
        step();
        bus.i_waitrequest = 1'b0;
        #1;
        chk("t1_read_c3", bus.o_read, 1'b1);
        chk("t1_m0_wait_c3", bus.o_m0_waitrequest, 1'b0);
        step();
        bus.i_m0_read = 1'b0;
        #1;
        chk("t1_rdwait_read", bus.o_read, 1'b0);
        chk("t1_rdwait_owner", bus.o_owner, 2'b01);
        chk("t1_rdwait_m0_wait", bus.o_m0_waitrequest, 1'b1);
        chk("t1_rdwait_burst", bus.o_burstcount, 8'd1);
        for (int i = 0; i < 8; i++) begin
            bus.i_readdatavalid = 1'b1;
            bus.i_readdata      = 32'hA000_0000 + 32'(i);
            #1;
            chk("t1_beat_owner", bus.o_owner, 2'b01);
            chk("t1_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
            chk("t1_m1_rdv", bus.o_m1_readdatavalid, 1'b0);
            chk("t1_m0_data", bus.o_m0_readdata, 32'hA000_0000 + 32'(i));
            step();
        end
        bus.i_readdatavalid = 1'b0;
        #1;
        chk("t1_done_owner", bus.o_owner, 2'b00);

`ifndef MEM_PORT_ARB_RR_EN
        // Simultaneous request: M1 store first, then M0 burst of 2.
        bus.i_m0_read       = 1'b1;
        bus.i_m0_addr       = 32'h200;
        bus.i_m0_burstcount = 8'd2;
        bus.i_m1_write      = 1'b1;
        bus.i_m1_addr       = 32'h300;
        bus.i_m1_writedata  = 32'hDEAD_BEEF;
        bus.i_m1_byteenable = 4'hF;
        bus.i_waitrequest   = 1'b1;
        step(); #1;
        chk("t2_owner_m1", bus.o_owner, 2'b10);
        chk("t2_write", bus.o_write, 1'b1);
        chk("t2_read", bus.o_read, 1'b0);
        chk("t2_addr", bus.o_addr, 32'h300);
        chk("t2_wdata", bus.o_writedata, 32'hDEAD_BEEF);
        chk("t2_be", bus.o_byteenable, 4'hF);
        chk("t2_burst", bus.o_burstcount, 8'd1);
        chk("t2_m1_wait_stall", bus.o_m1_waitrequest, 1'b1);
        chk("t2_m0_wait", bus.o_m0_waitrequest, 1'b1);
        step();
        bus.i_waitrequest = 1'b0;
        #1;
        chk("t2_m1_wait_acc", bus.o_m1_waitrequest, 1'b0);
        chk("t2_m0_wait_acc", bus.o_m0_waitrequest, 1'b1);
        step();
        bus.i_m1_write = 1'b0;
        #1;
        chk("t2_idle_owner", bus.o_owner, 2'b00);
        chk("t2_idle_m1_wait", bus.o_m1_waitrequest, 1'b1);
        chk("t2_idle_write", bus.o_write, 1'b0);
        step(); #1;
        chk("t2_owner_m0", bus.o_owner, 2'b01);
        chk("t2_m0_read", bus.o_read, 1'b1);
        chk("t2_m0_addr", bus.o_addr, 32'h200);
        chk("t2_m0_burst", bus.o_burstcount, 8'd2);
        step();
        bus.i_m0_read       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        bus.i_readdata      = 32'h11;
        #1;
        chk("t2_b0_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
        chk("t2_b0_m1_rdv", bus.o_m1_readdatavalid, 1'b0);
        chk("t2_b0_m1_data", bus.o_m1_readdata, 32'h11);
        step();
        bus.i_readdata = 32'h22;
        #1;
        chk("t2_b1_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
        chk("t2_b1_owner", bus.o_owner, 2'b01);
        step();
        bus.i_readdatavalid = 1'b0;
        #1;
        chk("t2_done_owner", bus.o_owner, 2'b00);
`endif

        // M0 burstcount 0 is issued and completed as a single beat.
        bus.i_m0_read       = 1'b1;
        bus.i_m0_addr       = 32'h40;
        bus.i_m0_burstcount = 8'd0;
        bus.i_waitrequest   = 1'b0;
        step(); #1;
        chk("t3_owner", bus.o_owner, 2'b01);
        chk("t3_burst", bus.o_burstcount, 8'd1);
        step();
        bus.i_m0_read       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("t3_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
        step();
        bus.i_readdatavalid = 1'b0;
        #1;
        chk("t3_done_owner", bus.o_owner, 2'b00);

        // M1 withdraws its load while stalled; M0 is then granted.
        bus.i_m1_read       = 1'b1;
        bus.i_m1_addr       = 32'h500;
        bus.i_m0_read       = 1'b1;
        bus.i_m0_addr       = 32'h600;
        bus.i_m0_burstcount = 8'd1;
        bus.i_waitrequest   = 1'b1;
        step(); #1;
        chk("t4_owner_m1", bus.o_owner, 2'b10);
        chk("t4_read", bus.o_read, 1'b1);
        chk("t4_addr", bus.o_addr, 32'h500);
        chk("t4_m1_wait", bus.o_m1_waitrequest, 1'b1);
        bus.i_m1_read = 1'b0;
        #1;
        chk("t4_drop_read", bus.o_read, 1'b0);
        step();
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("t4_idle_owner", bus.o_owner, 2'b00);
        chk("t4_stray_m1_rdv", bus.o_m1_readdatavalid, 1'b0);
        chk("t4_stray_m0_rdv", bus.o_m0_readdatavalid, 1'b0);
        step();
        bus.i_readdatavalid = 1'b0;
        bus.i_waitrequest   = 1'b0;
        #1;
        chk("t4_owner_m0", bus.o_owner, 2'b01);
        chk("t4_m0_addr", bus.o_addr, 32'h600);
        step();
        bus.i_m0_read       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("t4_m0_rdv", bus.o_m0_readdatavalid, 1'b1);
        chk("t4_m1_rdv", bus.o_m1_readdatavalid, 1'b0);
        step();
        bus.i_readdatavalid = 1'b0;
        #1;
        chk("t4_done_owner", bus.o_owner, 2'b00);

        // Reset in the middle of a 4-beat burst.
        bus.i_m0_read       = 1'b1;
        bus.i_m0_addr       = 32'h800;
        bus.i_m0_burstcount = 8'd4;
        step();
        step();
        bus.i_m0_read       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("t5_beat0_rdv", bus.o_m0_readdatavalid, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_owner", bus.o_owner, 2'b00);
        chk("t5_rst_m0_rdv", bus.o_m0_readdatavalid, 1'b0);
        chk("t5_rst_m0_wait", bus.o_m0_waitrequest, 1'b1);
        chk("t5_rst_m1_wait", bus.o_m1_waitrequest, 1'b1);
        chk("t5_rst_read", bus.o_read, 1'b0);
        chk("t5_rst_burst", bus.o_burstcount, 8'd1);
        chk("t5_rst_addr", bus.o_addr, 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_stale_m0_rdv", bus.o_m0_readdatavalid, 1'b0);
        chk("t5_stale_m1_rdv", bus.o_m1_readdatavalid, 1'b0);
        step(); #1;
        chk("t5_stale2_m0_rdv", bus.o_m0_readdatavalid, 1'b0);
        chk("t5_stale_owner", bus.o_owner, 2'b00);
        bus.i_readdatavalid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
